// File: rtl/beagleg_pkg.sv
// Shared command, state and status-bit definitions for the BeagleG SPI command frontend.
// Command encodings must match the host-side protocol enum.
package beagleg_pkg;

   typedef enum logic [7:0] {
      CMD_NO_OP      = 8'd0,
      CMD_STATUS     = 8'd1,
      CMD_WRITE_FIFO = 8'd2
   } command_t;

   typedef enum logic [1:0] {
      StIdle     = 2'd0,
      StGetCount = 2'd1,
      StReceive  = 2'd2
   } state_t;

   localparam int unsigned StatBusyBit     = 0;
   localparam int unsigned StatOverflowBit = 1;
   localparam int unsigned StatAbortBit    = 2;
   localparam int unsigned StatEmptyBit    = 3;

endpackage

// File: rtl/record_assembler.sv
// Collects SPI words into one motion record: word-index counter, shift register and
// a combinational completion strobe raised on the cycle the last word is accepted.
module record_assembler import beagleg_pkg::*; #(
   parameter int unsigned WORD_SIZE    = 8,
   parameter int unsigned RECORD_WORDS = 4
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                clear_i,
   input  logic                                word_valid_i,
   input  logic [WORD_SIZE-1:0]                word_i,
   output logic [RECORD_WORDS*WORD_SIZE-1:0]   rec_data_o,
   output logic                                last_o,
   output logic                                idx_nz_o
);

   localparam int unsigned IdxW = (RECORD_WORDS > 1) ? $clog2(RECORD_WORDS) : 1;
   localparam logic [IdxW-1:0] LastIdx = IdxW'(RECORD_WORDS - 1);

   logic [IdxW-1:0]                    idx_q, idx_d;
   logic [RECORD_WORDS*WORD_SIZE-1:0]  data_q, data_d, data_shift;
   logic                               take;

   assign take     = word_valid_i && !clear_i;
   assign last_o   = take && (idx_q == LastIdx);
   assign idx_nz_o = (idx_q != '0);

   // Words enter at the top, so after a full record word 0 has reached the LSBs.
   if (RECORD_WORDS == 1) begin : g_single
      assign data_shift = word_i;
   end else begin : g_multi
      assign data_shift = {word_i, data_q[RECORD_WORDS*WORD_SIZE-1:WORD_SIZE]};
   end

   always_comb begin
      idx_d  = idx_q;
      data_d = data_q;
      if (clear_i) begin
         idx_d = '0;
      end else if (word_valid_i) begin
         idx_d  = (idx_q == LastIdx) ? '0 : idx_q + 1'b1;
         data_d = data_shift;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q  <= '0;
         data_q <= '0;
      end else begin
         idx_q  <= idx_d;
         data_q <= data_d;
      end
   end

   assign rec_data_o = data_q;

endmodule

// File: rtl/beagleg_cmd_frontend.sv
// SPI command frontend: decodes host commands, assembles motion records for the
// downstream FIFO and returns free-slot count or status word on the next transfer.
module beagleg_cmd_frontend import beagleg_pkg::*; #(
   parameter int unsigned WORD_SIZE    = 8,
   parameter int unsigned RECORD_WORDS = 4,
   parameter int unsigned FIFO_SLOTS   = 16
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                spi_cs,
   input  logic [WORD_SIZE-1:0]                rx_word,
   input  logic                                rx_valid,
   output logic [WORD_SIZE-1:0]                tx_word,
   output logic [RECORD_WORDS*WORD_SIZE-1:0]   rec_data,
   output logic                                rec_valid,
   input  logic [$clog2(FIFO_SLOTS):0]         free_slots,
   input  logic                                engine_busy,
   output logic                                overflow
);

   localparam int unsigned FsW = $clog2(FIFO_SLOTS) + 1;

   state_t               state_q, state_d;
   logic [WORD_SIZE-1:0] cnt_q, cnt_d;
   logic [WORD_SIZE-1:0] tx_q, tx_d;
   logic                 rec_valid_q, rec_valid_d;
   logic                 overflow_q, overflow_d;
   logic                 abort_q, abort_d;
   logic                 status_sel_q, status_sel_d;

   logic                 accept, word_valid, rec_last, idx_nz;
   logic                 status_cap, ovf_set, abort_set;
   logic [WORD_SIZE-1:0] free_sat, status_word;

   assign accept     = rx_valid && !spi_cs;
   assign word_valid = accept && (state_q == StReceive);

   record_assembler #(
      .WORD_SIZE    (WORD_SIZE),
      .RECORD_WORDS (RECORD_WORDS)
   ) u_asm (
      .clk          (clk),
      .rst_n        (rst_n),
      .clear_i      (spi_cs),
      .word_valid_i (word_valid),
      .word_i       (rx_word),
      .rec_data_o   (rec_data),
      .last_o       (rec_last),
      .idx_nz_o     (idx_nz)
   );

   if (FsW > WORD_SIZE) begin : g_sat
      assign free_sat = (|free_slots[FsW-1:WORD_SIZE]) ? '1 : free_slots[WORD_SIZE-1:0];
   end else begin : g_ext
      assign free_sat = WORD_SIZE'(free_slots);
   end

   always_comb begin
      status_word                  = '0;
      status_word[StatBusyBit]     = engine_busy;
      status_word[StatOverflowBit] = overflow_q;
      status_word[StatAbortBit]    = abort_q;
      status_word[StatEmptyBit]    = (free_slots == FsW'(FIFO_SLOTS));
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (spi_cs) begin
         state_d = StIdle;
      end else if (rx_valid) begin
         case (state_q)
            StIdle: begin
               if (rx_word == WORD_SIZE'(CMD_WRITE_FIFO)) state_d = StGetCount;
            end
            StGetCount: begin
               cnt_d   = rx_word;
               state_d = StReceive;
            end
            StReceive: begin
               // A zero budget never counts down: stream until chip select rises.
               if (rec_last && (cnt_q != '0)) begin
                  cnt_d = cnt_q - 1'b1;
                  if (cnt_q == WORD_SIZE'(1)) state_d = StIdle;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   assign status_cap  = accept && (state_q == StIdle) && (rx_word == WORD_SIZE'(CMD_STATUS));
   assign ovf_set     = rec_last && (free_slots == '0);
   assign abort_set   = spi_cs && (state_q != StIdle) && idx_nz;
   assign rec_valid_d = rec_last && (free_slots != '0);
   assign overflow_d  = ovf_set | (overflow_q & ~status_cap);
   assign abort_d     = abort_set | (abort_q & ~status_cap);

   // The captured status word is held until the host sends its next word.
   always_comb begin
      tx_d         = tx_q;
      status_sel_d = status_sel_q;
      if (status_cap) begin
         tx_d         = status_word;
         status_sel_d = 1'b1;
      end else if (status_sel_q && !accept) begin
         tx_d         = tx_q;
      end else begin
         status_sel_d = 1'b0;
         tx_d         = (state_d == StIdle) ? free_sat : '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         cnt_q        <= '0;
         tx_q         <= '0;
         rec_valid_q  <= 1'b0;
         overflow_q   <= 1'b0;
         abort_q      <= 1'b0;
         status_sel_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         tx_q         <= tx_d;
         rec_valid_q  <= rec_valid_d;
         overflow_q   <= overflow_d;
         abort_q      <= abort_d;
         status_sel_q <= status_sel_d;
      end
   end

   assign tx_word   = tx_q;
   assign rec_valid = rec_valid_q;
   assign overflow  = overflow_q;

endmodule
